llc_cmd_frontend: RTL

Command front end for the last-level cache. It accepts trace commands (code plus 32-bit physical address) over a valid/ready handshake and splits each address into tag, index and byte offset. It classifies snoop commands into a bus operation and buffers the decoded requests in a small FIFO. The LLC controller sits directly downstream and pops one decoded request at a time. A clear command (code 8) acts as a barrier so nothing is queued behind it until the controller has taken it.

---
 rtl/llc_cmd_frontend_pkg.sv | 68 ++++++
 rtl/llc_cmd_frontend_req_fifo.sv | 65 ++++++
 rtl/llc_cmd_frontend.sv | 115 +++++++++++
 3 files changed

// File: rtl/llc_cmd_frontend_pkg.sv
// Shared LLC definitions: address split widths, bus operations, trace codes,
// the decoded-request record and the command decode helpers.
package llc_cmd_frontend_pkg;

   localparam int ADDR_BITS   = 32;
   localparam int TAG_BITS    = 12;
   localparam int INDEX       = 14;
   localparam int BYTE_OFFSET = 6;

   typedef enum logic [2:0] {
      NOBUSOP    = 3'd0,
      READ       = 3'd1,
      WRITE      = 3'd2,
      INVALIDATE = 3'd3,
      RWIM       = 3'd4
   } busOperation;

   typedef enum logic [3:0] {
      RD_DATA  = 4'd0,
      WR_DATA  = 4'd1,
      RD_INSTR = 4'd2,
      SNP_RD   = 4'd3,
      SNP_WR   = 4'd4,
      SNP_RWIM = 4'd5,
      SNP_INV  = 4'd6,
      CLEAR    = 4'd8,
      PRINT    = 4'd9
   } trace_code_e;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_BARRIER = 1'b1
   } fe_state_e;

   typedef struct packed {
      logic [3:0]             cmd;
      logic [TAG_BITS-1:0]    tag;
      logic [INDEX-1:0]       index;
      logic [BYTE_OFFSET-1:0] offset;
      logic                   snoop;
      busOperation            busop;
   } llc_req_t;

   // Codes 7 and 10-15 have no meaning in a trace file.
   function automatic logic is_legal_code(input logic [3:0] code);
      return (code <= 4'd6) || (code == 4'd8) || (code == 4'd9);
   endfunction

   function automatic llc_req_t decode_cmd(input logic [3:0] code,
                                           input logic [ADDR_BITS-1:0] addr);
      llc_req_t req;
      req.cmd    = code;
      req.tag    = addr[ADDR_BITS-1 -: TAG_BITS];
      req.index  = addr[BYTE_OFFSET +: INDEX];
      req.offset = addr[BYTE_OFFSET-1:0];
      req.snoop  = 1'b0;
      req.busop  = NOBUSOP;
      case (code)
         SNP_RD:   begin req.snoop = 1'b1; req.busop = READ;       end
         SNP_WR:   begin req.snoop = 1'b1; req.busop = WRITE;      end
         SNP_RWIM: begin req.snoop = 1'b1; req.busop = RWIM;       end
         SNP_INV:  begin req.snoop = 1'b1; req.busop = INVALIDATE; end
         default:  ;
      endcase
      return req;
   endfunction

endpackage

// File: rtl/llc_cmd_frontend_req_fifo.sv
// llc_req_fifo: DEPTH-entry FIFO of decoded LLC requests.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_push, i_wdata  write request and entry (ignored when full)
//   i_pop            read request (ignored when empty)
//   o_rdata          head entry, valid whenever o_empty=0
//   o_count          occupancy 0..DEPTH
//   o_empty, o_full  status flags
module llc_req_fifo
   import llc_cmd_frontend_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  llc_req_t                 i_wdata,
   input  logic                     i_pop,
   output llc_req_t                 o_rdata,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int PW = $clog2(DEPTH);

   llc_req_t        r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW:0]     r_count;
   logic            w_push;
   logic            w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (PW+1)'(DEPTH));
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // Head is read combinationally so an entry is visible the cycle after its push.
   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/llc_cmd_frontend.sv
// llc_cmd_frontend: accepts trace commands, decodes the address into
// tag/index/offset and the snoop bus operation, and queues the decoded
// requests for the LLC controller. A clear (code 8) blocks further input
// until the controller has popped it. Illegal codes are dropped and counted.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         input handshake; in_cmd, in_addr payload
//   out_valid/out_ready       output handshake for the head entry
//   out_cmd..out_busop        decoded head entry
//   count                     FIFO occupancy
//   err_illegal               one-cycle pulse per dropped illegal code
//   illegal_count             saturating count of dropped codes
module llc_cmd_frontend
   import llc_cmd_frontend_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_cmd,
   input  logic [31:0]              in_addr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               out_cmd,
   output logic [TAG_BITS-1:0]      out_tag,
   output logic [INDEX-1:0]         out_index,
   output logic [BYTE_OFFSET-1:0]   out_offset,
   output logic                     out_snoop,
   output busOperation              out_busop,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err_illegal,
   output logic [15:0]              illegal_count
);

   fe_state_e             r_state;
   fe_state_e             w_state_next;
   logic                  r_err_illegal;
   logic [15:0]           r_illegal_count;

   logic                  w_accept;
   logic                  w_legal;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_pop;
   logic                  w_fifo_empty;
   logic                  w_fifo_full;
   llc_req_t              w_wdata;
   llc_req_t              w_head;
   logic [$clog2(DEPTH):0] w_count;

   // Only registered state feeds in_ready; out_ready is deliberately absent.
   assign in_ready = (r_state == ST_RUN) && !w_fifo_full;
   assign w_accept = in_valid && in_ready;
   assign w_legal  = is_legal_code(in_cmd);
   assign w_push   = w_accept && w_legal;
   assign w_drop   = w_accept && !w_legal;
   assign w_pop    = !w_fifo_empty && out_ready;
   assign w_wdata  = decode_cmd(in_cmd, in_addr);

   llc_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_state_next;
   end

   // While blocked nothing can be pushed behind the clear, so the clear
   // reaching the head and being popped is the only way back to RUN.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN:     if (w_push && (in_cmd == CLEAR)) w_state_next = ST_BARRIER;
         ST_BARRIER: if (w_pop && (w_head.cmd == CLEAR)) w_state_next = ST_RUN;
         default:    w_state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_illegal   <= 1'b0;
         r_illegal_count <= '0;
      end else begin
         r_err_illegal <= w_drop;
         if (w_drop && (r_illegal_count != 16'hFFFF))
            r_illegal_count <= r_illegal_count + 16'd1;
      end
   end

   assign out_valid     = !w_fifo_empty;
   assign out_cmd       = w_head.cmd;
   assign out_tag       = w_head.tag;
   assign out_index     = w_head.index;
   assign out_offset    = w_head.offset;
   // Masked so stale storage never shows up as a snoop while empty.
   assign out_snoop     = out_valid && w_head.snoop;
   assign out_busop     = out_valid ? w_head.busop : NOBUSOP;
   assign count         = w_count;
   assign err_illegal   = r_err_illegal;
   assign illegal_count = r_illegal_count;

endmodule
